// File: rtl/alu_ctrl_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl_stage
//  Purpose  : Registered multi-lane ALU-control decoder. Decodes LANES
//             instructions per bundle into ALU_operation_t codes, flags RV32M
//             ops and illegal encodings, and buffers the decoded bundle behind
//             a valid/ready handshake with a one-entry skid buffer so that
//             in_ready is a pure register output.
//  Ports    :
//    clk, rst            clock, synchronous active-high reset
//    flush               drop buffered bundles and the same-cycle input
//    in_valid/in_ready   input handshake (in_ready registered, = !skid full)
//    in_lane_valid       per-lane valid
//    in_insn             LANES x 32-bit instructions, lane i at [32i+31:32i]
//    in_alu_op           LANES x 2-bit alu_op from the main decoder
//    out_valid/out_ready output handshake
//    out_lane_valid      registered lane valids
//    out_insn            registered instruction pass-through
//    out_alu_operation   LANES x OP_W decoded operation
//    out_is_muldiv       lane is an RV32M op
//    out_md_funct3       funct3 of RV32M lanes, else 0
//    out_illegal         unsupported encoding
//    stall_cnt           saturating count of out_valid && !out_ready cycles
//  Revision : 1.0 - initial release
// ============================================================================
module alu_ctrl_stage #(
  parameter int LANES = 2,
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES-1:0]      in_lane_valid,
  input  logic [LANES*32-1:0]   in_insn,
  input  logic [LANES*2-1:0]    in_alu_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      out_lane_valid,
  output logic [LANES*32-1:0]   out_insn,
  output logic [LANES*OP_W-1:0] out_alu_operation,
  output logic [LANES-1:0]      out_is_muldiv,
  output logic [LANES*3-1:0]    out_md_funct3,
  output logic [LANES-1:0]      out_illegal,
  output logic [CNT_W-1:0]      stall_cnt
);

  // ALU_operation_t encoding. alu_op values other than 2'b10 pass straight
  // through zero-extended, so add/sub must sit at 0/1.
  localparam logic [OP_W-1:0] c_ADD_ALU  = OP_W'(0);
  localparam logic [OP_W-1:0] c_SUB_ALU  = OP_W'(1);
  localparam logic [OP_W-1:0] c_AND_ALU  = OP_W'(2);
  localparam logic [OP_W-1:0] c_OR_ALU   = OP_W'(3);
  localparam logic [OP_W-1:0] c_XOR_ALU  = OP_W'(4);
  localparam logic [OP_W-1:0] c_SLL_ALU  = OP_W'(5);
  localparam logic [OP_W-1:0] c_SRL_ALU  = OP_W'(6);
  localparam logic [OP_W-1:0] c_SRA_ALU  = OP_W'(7);
  localparam logic [OP_W-1:0] c_SLT_ALU  = OP_W'(8);
  localparam logic [OP_W-1:0] c_SLTU_ALU = OP_W'(9);
  localparam logic [OP_W-1:0] c_LUI_ALU  = OP_W'(10);
  localparam logic [OP_W-1:0] c_NO_ALU   = OP_W'(15);

  localparam logic [6:0] c_OPC_R      = 7'b0110011;
  localparam logic [6:0] c_OPC_I      = 7'b0010011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;

  localparam logic [6:0] c_F7_BASE = 7'h00;
  localparam logic [6:0] c_F7_ALT  = 7'h20;
  localparam logic [6:0] c_F7_MD   = 7'h01;

  // Decoded bundle layout, MSB to LSB:
  //   lane_valid[L] | insn[32L] | op[OP_W*L] | is_muldiv[L] | md_f3[3L] | illegal[L]
  localparam int BW      = LANES * (1 + 32 + OP_W + 1 + 3 + 1);
  localparam int OFS_ILL = 0;
  localparam int OFS_F3  = OFS_ILL + LANES;
  localparam int OFS_MD  = OFS_F3 + 3 * LANES;
  localparam int OFS_OP  = OFS_MD + LANES;
  localparam int OFS_IN  = OFS_OP + OP_W * LANES;
  localparam int OFS_LV  = OFS_IN + 32 * LANES;

  // Reset image: everything zero except each lane's op, which reads noALU.
  localparam logic [BW-1:0] c_RST_BUNDLE =
    BW'({LANES{c_NO_ALU}}) << OFS_OP;

  // funct3 -> operation for the register/immediate arithmetic group
  function automatic logic [OP_W-1:0] base_op(input logic [2:0] f3);
    logic [OP_W-1:0] op;
    case (f3)
      3'd0:    op = c_ADD_ALU;
      3'd1:    op = c_SLL_ALU;
      3'd2:    op = c_SLT_ALU;
      3'd3:    op = c_SLTU_ALU;
      3'd4:    op = c_XOR_ALU;
      3'd5:    op = c_SRL_ALU;
      3'd6:    op = c_OR_ALU;
      default: op = c_AND_ALU;
    endcase
    return op;
  endfunction

  // Returns {illegal, is_muldiv, md_funct3[2:0], op[OP_W-1:0]}
  function automatic logic [OP_W+4:0] decode_lane(
    input logic        lv,
    input logic [31:0] insn,
    input logic [1:0]  alu_op
  );
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [OP_W-1:0] op;
    logic            ill;
    logic            md;
    logic [2:0]      mf3;
    opc = insn[6:0];
    f3  = insn[14:12];
    f7  = insn[31:25];
    op  = c_NO_ALU;
    ill = 1'b0;
    md  = 1'b0;
    mf3 = 3'd0;
    if (!lv) begin
      op = c_NO_ALU;
    end else if (alu_op != 2'b10) begin
      op = OP_W'(alu_op);
    end else begin
      case (opc)
        c_OPC_R: begin
          if (f7 == c_F7_BASE) begin
            op = base_op(f3);
          end else if (f7 == c_F7_ALT) begin
            if (f3 == 3'd0)      op = c_SUB_ALU;
            else if (f3 == 3'd5) op = c_SRA_ALU;
            else                 ill = 1'b1;
          end else if (f7 == c_F7_MD) begin
            md  = 1'b1;
            mf3 = f3;
          end else begin
            ill = 1'b1;
          end
        end
        c_OPC_I: begin
          // Only the shift-immediates constrain the upper immediate bits.
          if (f3 == 3'd1) begin
            if (f7 == c_F7_BASE) op = c_SLL_ALU;
            else                 ill = 1'b1;
          end else if (f3 == 3'd5) begin
            if (f7 == c_F7_BASE)     op = c_SRL_ALU;
            else if (f7 == c_F7_ALT) op = c_SRA_ALU;
            else                     ill = 1'b1;
          end else begin
            op = base_op(f3);
          end
        end
        c_OPC_LOAD, c_OPC_STORE, c_OPC_JALR,
        c_OPC_JAL, c_OPC_AUIPC:  op = c_ADD_ALU;
        c_OPC_BRANCH:            op = c_SUB_ALU;
        c_OPC_LUI:               op = c_LUI_ALU;
        default:                 ill = 1'b1;
      endcase
    end
    return {ill, md, mf3, op};
  endfunction

  // ---------------------------------------------------------------------------
  // Input-side decode
  // ---------------------------------------------------------------------------
  logic [BW-1:0]          w_dec_bundle;
  logic [LANES*OP_W-1:0]  w_op;
  logic [LANES-1:0]       w_md;
  logic [LANES*3-1:0]     w_f3;
  logic [LANES-1:0]       w_ill;

  always_comb begin
    logic [OP_W+4:0] d;
    w_op  = '0;
    w_md  = '0;
    w_f3  = '0;
    w_ill = '0;
    d     = '0;
    for (int i = 0; i < LANES; i++) begin
      d = decode_lane(in_lane_valid[i], in_insn[32*i +: 32], in_alu_op[2*i +: 2]);
      w_op[OP_W*i +: OP_W] = d[OP_W-1:0];
      w_f3[3*i +: 3]       = d[OP_W+2:OP_W];
      w_md[i]              = d[OP_W+3];
      w_ill[i]             = d[OP_W+4];
    end
  end

  assign w_dec_bundle = {in_lane_valid, in_insn, w_op, w_md, w_f3, w_ill};

  // ---------------------------------------------------------------------------
  // Output register + skid buffer
  // ---------------------------------------------------------------------------
  logic          r_out_valid;
  logic [BW-1:0] r_out_data;
  logic          r_skid_valid;
  logic [BW-1:0] r_skid_data;
  logic          r_in_ready;
  logic [CNT_W-1:0] r_stall_cnt;

  logic          w_accept;
  logic          w_fire;
  logic          w_nxt_out_valid;
  logic [BW-1:0] w_nxt_out_data;
  logic          w_nxt_skid_valid;
  logic [BW-1:0] w_nxt_skid_data;

  assign w_accept = in_valid && r_in_ready && !flush;
  assign w_fire   = r_out_valid && out_ready;

  always_comb begin
    w_nxt_out_valid  = r_out_valid;
    w_nxt_out_data   = r_out_data;
    w_nxt_skid_valid = r_skid_valid;
    w_nxt_skid_data  = r_skid_data;
    if (flush) begin
      w_nxt_out_valid  = 1'b0;
      w_nxt_skid_valid = 1'b0;
    end else if (!r_out_valid || w_fire) begin
      // Output slot frees up: the skid entry is older than any new input.
      // While the skid is full in_ready is low, so no accept can collide.
      if (r_skid_valid) begin
        w_nxt_out_valid  = 1'b1;
        w_nxt_out_data   = r_skid_data;
        w_nxt_skid_valid = 1'b0;
      end else if (w_accept) begin
        w_nxt_out_valid = 1'b1;
        w_nxt_out_data  = w_dec_bundle;
      end else begin
        w_nxt_out_valid = 1'b0;
      end
    end else if (w_accept) begin
      w_nxt_skid_valid = 1'b1;
      w_nxt_skid_data  = w_dec_bundle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= c_RST_BUNDLE;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_in_ready   <= 1'b1;
    end else begin
      r_out_valid  <= w_nxt_out_valid;
      r_out_data   <= w_nxt_out_data;
      r_skid_valid <= w_nxt_skid_valid;
      r_skid_data  <= w_nxt_skid_data;
      r_in_ready   <= !w_nxt_skid_valid;
    end
  end

  // Stall counter survives flush; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready          = r_in_ready;
  assign out_valid         = r_out_valid;
  assign stall_cnt         = r_stall_cnt;
  assign out_lane_valid    = r_out_data[OFS_LV +: LANES];
  assign out_insn          = r_out_data[OFS_IN +: 32*LANES];
  assign out_alu_operation = r_out_data[OFS_OP +: OP_W*LANES];
  assign out_is_muldiv     = r_out_data[OFS_MD +: LANES];
  assign out_md_funct3     = r_out_data[OFS_F3 +: 3*LANES];
  assign out_illegal       = r_out_data[OFS_ILL +: LANES];

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_ctrl_stage
//  Purpose  : Directed self-checking bench for alu_ctrl_stage (LANES=2) plus a
//             CNT_W=4 instance for stall-counter saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_stage;

  // ALU_operation_t codes
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, SRA = 4'd7,
                         SLT = 4'd8, LUI = 4'd10, NOP = 4'd15;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [1:0]  in_lane_valid;
  logic [63:0] in_insn;
  logic [3:0]  in_alu_op;

  logic        in_ready, out_valid;
  logic [1:0]  out_lane_valid, out_is_muldiv, out_illegal;
  logic [63:0] out_insn;
  logic [7:0]  out_alu_operation;
  logic [5:0]  out_md_funct3;
  logic [15:0] stall_cnt;

  logic        in_valid4, out_ready4;
  logic        in_ready4, out_valid4;
  logic [1:0]  out_lane_valid4, out_is_muldiv4, out_illegal4;
  logic [63:0] out_insn4;
  logic [7:0]  out_alu_operation4;
  logic [5:0]  out_md_funct3_4;
  logic [3:0]  stall_cnt4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_ctrl_stage #(.LANES(2), .OP_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_valid(in_lane_valid), .in_insn(in_insn), .in_alu_op(in_alu_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lane_valid(out_lane_valid), .out_insn(out_insn),
    .out_alu_operation(out_alu_operation), .out_is_muldiv(out_is_muldiv),
    .out_md_funct3(out_md_funct3), .out_illegal(out_illegal),
    .stall_cnt(stall_cnt)
  );

  alu_ctrl_stage #(.LANES(2), .OP_W(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_lane_valid(in_lane_valid), .in_insn(in_insn), .in_alu_op(in_alu_op),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_lane_valid(out_lane_valid4), .out_insn(out_insn4),
    .out_alu_operation(out_alu_operation4), .out_is_muldiv(out_is_muldiv4),
    .out_md_funct3(out_md_funct3_4), .out_illegal(out_illegal4),
    .stall_cnt(stall_cnt4)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    n_vec++;
    if (out_alu_operation !== {NOP, NOP} || out_insn !== 64'd0 || out_lane_valid !== 2'b00) begin
      n_err++; $display("FAIL reset_data: op=%h insn=%h lv=%b want ff 0 00",
                        out_alu_operation, out_insn, out_lane_valid);
    end
    n_vec++;
    if (stall_cnt !== 16'd0 || out_illegal !== 2'b00 || out_is_muldiv !== 2'b00) begin
      n_err++; $display("FAIL reset_cnt: cnt=%0d ill=%b md=%b want 0 00 00",
                        stall_cnt, out_illegal, out_is_muldiv);
    end
  endtask

  task automatic test_add_sub;
    out_ready = 1'b1; in_lane_valid = 2'b11; in_alu_op = 4'b1010;
    in_insn = {32'h40B50533, 32'h00B50533};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_alu_operation !== {SUB, ADD} || out_illegal !== 2'b00) begin
      n_err++; $display("FAIL add_sub: v=%b op=%h ill=%b want 1 10 00",
                        out_valid, out_alu_operation, out_illegal);
    end
    n_vec++;
    if (out_insn !== {32'h40B50533, 32'h00B50533}) begin
      n_err++; $display("FAIL add_sub_insn: got %h", out_insn);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_muldiv;
    in_insn = {32'h02B54533, 32'h02B50533};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_vec++;
    if (out_is_muldiv !== 2'b11 || out_md_funct3 !== {3'd4, 3'd0} ||
        out_alu_operation !== {NOP, NOP} || out_illegal !== 2'b00) begin
      n_err++; $display("FAIL muldiv: md=%b f3=%b op=%h ill=%b want 11 100000 ff 00",
                        out_is_muldiv, out_md_funct3, out_alu_operation, out_illegal);
    end
  endtask

  task automatic test_illegal;
    in_valid = 1'b1;
    in_insn = {32'h40B51513, 32'h20B50533};
    in_alu_op = 4'b1010;
    step();
    n_vec++;
    if (out_illegal !== 2'b11 || out_alu_operation !== {NOP, NOP} || out_is_muldiv !== 2'b00) begin
      n_err++; $display("FAIL illegal_f7: ill=%b op=%h md=%b want 11 ff 00",
                        out_illegal, out_alu_operation, out_is_muldiv);
    end
    in_insn = {32'h000015B7, 32'h0000007F};
    step();
    n_vec++;
    if (out_illegal !== 2'b01 || out_alu_operation !== {LUI, NOP}) begin
      n_err++; $display("FAIL illegal_opc: ill=%b op=%h want 01 af", out_illegal, out_alu_operation);
    end
    in_insn = {32'h40B51513, 32'h20B50533};
    in_alu_op = 4'b0000;
    step();
    n_vec++;
    if (out_illegal !== 2'b00 || out_alu_operation !== {ADD, ADD}) begin
      n_err++; $display("FAIL aluop00: ill=%b op=%h want 00 00", out_illegal, out_alu_operation);
    end
    in_insn = {32'h000015B7, 32'h0000007F};
    in_alu_op = 4'b0100;
    step();
    in_valid = 1'b0;
    n_vec++;
    if (out_illegal !== 2'b00 || out_alu_operation !== {SUB, ADD}) begin
      n_err++; $display("FAIL aluop01: ill=%b op=%h want 00 10", out_illegal, out_alu_operation);
    end
  endtask

  task automatic test_misc_decode;
    in_valid = 1'b1; in_alu_op = 4'b1010;
    in_insn = {32'h00B50463, 32'h40B55513};   // branch, srai
    step();
    n_vec++;
    if (out_alu_operation !== {SUB, SRA} || out_illegal !== 2'b00) begin
      n_err++; $display("FAIL br_srai: op=%h ill=%b want 17 00", out_alu_operation, out_illegal);
    end
    in_insn = {32'h00B57533, 32'h00052503};   // and, load
    step();
    n_vec++;
    if (out_alu_operation !== {AND_, ADD}) begin
      n_err++; $display("FAIL and_ld: op=%h want 20", out_alu_operation);
    end
    in_insn = {32'h40B51533, 32'h00B52533};   // R f7=20 f3=1 (illegal), slt
    step();
    in_valid = 1'b0;
    n_vec++;
    if (out_alu_operation !== {NOP, SLT} || out_illegal !== 2'b10) begin
      n_err++; $display("FAIL r20_slt: op=%h ill=%b want f8 10", out_alu_operation, out_illegal);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] a, b, c;
    a = {32'h40B50533, 32'h00B50533};
    b = {32'h00B57533, 32'h00B52533};
    c = {32'h00052503, 32'h02B50533};
    do_reset();
    in_alu_op = 4'b1010; in_lane_valid = 2'b11;
    out_ready = 1'b0; in_valid = 1'b1; in_insn = a;
    step();
    n_vec++;
    if (out_valid !== 1'b1 || out_insn !== a || in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_a: v=%b insn=%h rdy=%b", out_valid, out_insn, in_ready);
    end
    in_insn = b;
    step();
    n_vec++;
    if (out_insn !== a || in_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_skid: insn=%h rdy=%b want A 0", out_insn, in_ready);
    end
    in_insn = c;
    repeat (3) step();
    n_vec++;
    if (out_insn !== a || in_ready !== 1'b0 || stall_cnt !== 16'd4) begin
      n_err++; $display("FAIL bp_hold: insn=%h rdy=%b cnt=%0d want A 0 4", out_insn, in_ready, stall_cnt);
    end
    out_ready = 1'b1;
    step();
    n_vec++;
    if (out_valid !== 1'b1 || out_insn !== b || in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_b: v=%b insn=%h rdy=%b want 1 B 1", out_valid, out_insn, in_ready);
    end
    step();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_insn !== c || out_alu_operation !== {ADD, NOP} ||
        out_is_muldiv !== 2'b01) begin
      n_err++; $display("FAIL bp_c: v=%b insn=%h op=%h md=%b want 1 C 0f 01",
                        out_valid, out_insn, out_alu_operation, out_is_muldiv);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b0 || stall_cnt !== 16'd4) begin
      n_err++; $display("FAIL bp_end: v=%b cnt=%0d want 0 4", out_valid, stall_cnt);
    end
  endtask

  task automatic test_flush;
    int seen;
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_insn = {32'h40B50533, 32'h00B50533};
    step();
    in_insn = {32'h00B57533, 32'h00B52533};
    step();
    flush = 1'b1;
    in_insn = {32'h00052503, 32'h02B50533};
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 16'd2) begin
      n_err++; $display("FAIL flush: v=%b rdy=%b cnt=%0d want 0 1 2", out_valid, in_ready, stall_cnt);
    end
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (out_valid !== 1'b0) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++; $display("FAIL flush_leak: valid cycles=%0d want 0", seen);
    end
    in_valid = 1'b1;
    in_insn = {32'h000015B7, 32'h00B50463};
    step();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_alu_operation !== {LUI, SUB}) begin
      n_err++; $display("FAIL post_flush: v=%b op=%h want 1 a1", out_valid, out_alu_operation);
    end
  endtask

  task automatic test_saturate;
    do_reset();
    in_lane_valid = 2'b01; in_alu_op = 4'b1010;
    in_insn = {32'h00B50533, 32'h40B50533};
    in_valid4 = 1'b1; out_ready4 = 1'b0;
    step();
    in_valid4 = 1'b0;
    repeat (20) step();
    n_vec++;
    if (stall_cnt4 !== 4'd15) begin
      n_err++; $display("FAIL sat: cnt=%0d want 15", stall_cnt4);
    end
    n_vec++;
    if (out_alu_operation4 !== {NOP, SUB} || out_lane_valid4 !== 2'b01 ||
        out_is_muldiv4 !== 2'b00 || out_md_funct3_4 !== 6'd0 || out_illegal4 !== 2'b00) begin
      n_err++; $display("FAIL lane_inv: op=%h lv=%b md=%b f3=%b ill=%b want f1 01 00 0 00",
                        out_alu_operation4, out_lane_valid4, out_is_muldiv4,
                        out_md_funct3_4, out_illegal4);
    end
    repeat (2) step();
    n_vec++;
    if (stall_cnt4 !== 4'd15 || out_valid4 !== 1'b1) begin
      n_err++; $display("FAIL sat_hold: cnt=%0d v=%b want 15 1", stall_cnt4, out_valid4);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    if (stall_cnt4 !== 4'd0 || out_valid4 !== 1'b0 || in_ready4 !== 1'b1 ||
        out_alu_operation4 !== {NOP, NOP}) begin
      n_err++; $display("FAIL rst_mid: cnt=%0d v=%b rdy=%b op=%h want 0 0 1 ff",
                        stall_cnt4, out_valid4, in_ready4, out_alu_operation4);
    end
    out_ready4 = 1'b1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_lane_valid = 2'b11; in_insn = 64'd0; in_alu_op = 4'b1010;
    in_valid4 = 1'b0; out_ready4 = 1'b1;
    test_reset();
    test_add_sub();
    test_muldiv();
    test_illegal();
    test_misc_decode();
    test_back_to_back();
    test_flush();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
Registered, multi-lane successor to the combinational ALU-control decoder. It decodes LANES instructions per cycle into ALU_operation_t (from opTypes.svh), adds RV32M recognition and illegal-encoding flags, and buffers results behind a valid/ready handshake with a one-entry skid buffer. It sits between the decode/rename boundary and issue, so in_ready is a pure register output and issue back-pressure never reaches decode combinationally.

Parameters:
LANES, 2, instructions decoded per bundle (1..4)
OP_W, 4, bit width of ALU_operation_t
CNT_W, 16, width of the saturating stall counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  drop all buffered bundles and the same-cycle input
in_valid  in  1  input bundle valid
in_ready  out  1  stage can accept a bundle; registered, equals !skid_valid
in_lane_valid  in  LANES  per-lane valid within the bundle
in_insn  in  LANES*32  instructions; lane i occupies bits [32i+31:32i]
in_alu_op  in  LANES*2  per-lane alu_op control from main decoder
out_valid  out  1  output bundle valid
out_ready  in  1  consumer accepts the bundle
out_lane_valid  out  LANES  registered copy of in_lane_valid
out_insn  out  LANES*32  registered instruction pass-through
out_alu_operation  out  LANES*OP_W  decoded ALU_operation_t per lane
out_is_muldiv  out  LANES  lane is an RV32M op
out_md_funct3  out  LANES*3  funct3 for RV32M lanes, else 0
out_illegal  out  LANES  unsupported encoding
stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating

Behaviour:
- Reset: out_valid=0, skid empty, in_ready=1, stall_cnt=0, all out_* data=0, out_alu_operation=noALU.
- Per-lane decode, combinational on the input side, registered once:
  - lane invalid: noALU, is_muldiv=0, md_funct3=0, illegal=0.
  - alu_op!=2'b10: op = zero-extended alu_op to OP_W; illegal=0; is_muldiv=0.
  - alu_op==2'b10 base table: R-type (0110011) funct7=00 -> add/xor/or/and/sll/srl/slt/sltu by funct3; funct7=20 -> sub (f3=0) or sra (f3=5). I-type (0010011) same funct3 map; f3=5 uses insn[31:25] 00->srl, 20->sra. Load, JALR, store, JAL and AUIPC -> addALU; branch -> subALU; LUI -> luiALU.
  - RV32M: R-type with funct7=01 -> is_muldiv=1, md_funct3=funct3, op=noALU.
  - illegal=1 with op=noALU when: the opcode is not in the table; R-type funct7 is not in {00,20,01}; R-type funct7=20 with funct3 not in {0,5}; I-type f3=1 with insn[31:25]!=00; I-type f3=5 with insn[31:25] not in {00,20}.
- Latency: an accepted bundle appears on out_* in the next cycle when the output register is free or draining.
- Handshake: accept = in_valid && in_ready && !flush. Output fire = out_valid && out_ready. out_* hold stable while out_valid && !out_ready.
- Buffer transitions, with skid S:
  - accept, output empty or firing, S empty: load output.
  - accept, output stalled: load S; in_ready=0 next cycle.
  - fire with S full: S moves to output; S empties; in_ready=1 next cycle.
  - S is never full while accept occurs, because in_ready=0 whenever S is full.
- flush: next cycle out_valid=0, S empty, in_ready=1. Any same-cycle input is discarded. Flush overrides accept and fire. stall_cnt is not reset by flush.
- stall_cnt: increments each cycle out_valid && !out_ready; saturates at all-ones; cleared only by rst.
- rst mid-stall: all state returns to reset values next cycle.

Test Plan:
- Reset, then one bundle: lane0 0x00B50533 (add, alu_op=10), lane1 0x40B50533 (sub) -> next cycle out_valid=1 with ops addALU and subALU; illegal=00.
- Lane0 0x02B50533 (mul), lane1 0x02B54533 (div) -> is_muldiv=11, md_funct3={4,0}, ops noALU.
- Illegal cases: 0x20B50533 (funct7=10), 0x40B51513 (slli with f7=20), opcode 0x7F -> illegal=1, noALU; the same words with alu_op=00 -> addALU, illegal=0.
- Back-pressure: hold out_ready=0 and offer bundles A, B, C -> A on output, B in skid, in_ready=0, C not taken. Then out_ready=1 -> A, B, C delivered in order with no loss or duplication; stall_cnt equals the number of stalled cycles.
- Flush with output and skid full plus in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears.
- CNT_W=4 with out_ready=0 held for 20 cycles -> stall_cnt=15 and it holds there; lane_valid=01 -> lane1 outputs noALU with all flags 0.
